// File: rtl/exu_pkg.sv
// Shared definitions for the exu ALU and the two-client arbiter that feeds it:
// datapath width, opcode encodings and opcode classification helpers.
package exu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRA  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  localparam logic [3:0] ALU_OP_MAX = 4'h9;

  typedef logic [XLEN-1:0] xword_t;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/exu_arbiter_if.sv
// Request/response bundle between the two exu clients, the arbiter and the
// response consumer. master = client/consumer side, slave = arbiter side.
interface exu_arbiter_if;
  import exu_pkg::*;

  logic       req0_valid;
  logic       req0_ready;
  xword_t     req0_a;
  xword_t     req0_b;
  logic [3:0] req0_op;

  logic       req1_valid;
  logic       req1_ready;
  xword_t     req1_a;
  xword_t     req1_b;
  logic [3:0] req1_op;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  xword_t     rsp_data;
  logic       rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/exu.sv
// Combinational integer ALU. Shift amounts use only b[4:0]; unknown opcodes
// produce zero so the caller can flag them without a separate result path.
module exu
  import exu_pkg::*;
(
  input  xword_t     a_i,
  input  xword_t     b_i,
  input  logic [3:0] op_i,
  output xword_t     result_o
);

  // ALU result selection
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/exu_arbiter.sv
// Round-robin arbiter sharing one exu between two requesters, with a one-entry
// registered response buffer that may be refilled in the cycle it drains.
module exu_arbiter
  import exu_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  exu_arbiter_if.slave bus
);

  // last_grant resets to the opposite of the preferred requester so that the
  // first contended grant lands on RESET_PRIO.
  localparam logic LAST_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  logic       can_accept_s;
  logic       gnt_valid_s;
  logic       gnt_idx_s;
  xword_t     sel_a_s;
  xword_t     sel_b_s;
  logic [3:0] sel_op_s;
  xword_t     exu_b_s;
  xword_t     exu_res_s;

  logic       rsp_valid_q, rsp_valid_d;
  xword_t     rsp_data_q,  rsp_data_d;
  logic       rsp_id_q,    rsp_id_d;
  logic       rsp_err_q,   rsp_err_d;
  logic       last_grant_q, last_grant_d;

  // Grant selection: a lone requester wins, contention goes to the one not served last
  always_comb begin
    can_accept_s = !rsp_valid_q || bus.rsp_ready;
    gnt_valid_s  = 1'b0;
    gnt_idx_s    = 1'b0;
    if (rst || !can_accept_s) begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = !last_grant_q;
    end else if (bus.req0_valid) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = 1'b0;
    end else if (bus.req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = 1'b0;
    end
  end

  assign bus.req0_ready = gnt_valid_s && !gnt_idx_s;
  assign bus.req1_ready = gnt_valid_s &&  gnt_idx_s;

  // Operand mux into the shared ALU, with shift amounts masked to five bits
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = ALU_ADD;
    exu_b_s  = '0;
    if (gnt_idx_s) begin
      sel_a_s  = bus.req1_a;
      sel_b_s  = bus.req1_b;
      sel_op_s = bus.req1_op;
    end else begin
      sel_a_s  = bus.req0_a;
      sel_b_s  = bus.req0_b;
      sel_op_s = bus.req0_op;
    end
    if (op_is_shift(sel_op_s)) begin
      exu_b_s = {{(XLEN-5){1'b0}}, sel_b_s[4:0]};
    end else begin
      exu_b_s = sel_b_s;
    end
  end

  exu u_exu (
    .a_i      (sel_a_s),
    .b_i      (exu_b_s),
    .op_i     (sel_op_s),
    .result_o (exu_res_s)
  );

  // Response buffer next state: accept overwrites, drain without accept empties
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    if (gnt_valid_s) begin
      rsp_valid_d  = 1'b1;
      rsp_data_d   = op_is_illegal(sel_op_s) ? '0 : exu_res_s;
      rsp_id_d     = gnt_idx_s;
      rsp_err_d    = op_is_illegal(sel_op_s);
      last_grant_d = gnt_idx_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end else begin
      rsp_valid_d  = rsp_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= LAST_RST;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_exu_arbiter.sv
// Self-checking bench for exu_arbiter: directed vector table, hand-written
// contention/backpressure/reset sequences, then random traffic against a model.
module tb_exu_arbiter;
  import exu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exu_arbiter_if bus_if ();

  exu_arbiter #(.RESET_PRIO(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus_if.req0_valid = 1'b0; bus_if.req0_a = 32'h0; bus_if.req0_b = 32'h0; bus_if.req0_op = 4'h0;
    bus_if.req1_valid = 1'b0; bus_if.req1_a = 32'h0; bus_if.req1_b = 32'h0; bus_if.req1_op = 4'h0;
    bus_if.rsp_ready  = 1'b1;
  endtask

  task automatic put(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (id) begin
      bus_if.req1_valid = 1'b1; bus_if.req1_a = a; bus_if.req1_b = b; bus_if.req1_op = op;
    end else begin
      bus_if.req0_valid = 1'b1; bus_if.req0_a = a; bus_if.req0_b = b; bus_if.req0_op = op;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    #1;
    chk1("ready0_during_reset", bus_if.req0_ready, 1'b0);
    chk1("ready1_during_reset", bus_if.req1_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk1("reset_rsp_valid", bus_if.rsp_valid, 1'b0);
    chk("reset_rsp_data", bus_if.rsp_data, 32'h0);
    chk1("reset_rsp_id", bus_if.rsp_id, 1'b0);
    chk1("reset_rsp_err", bus_if.rsp_err, 1'b0);
  endtask

  // Reference ALU from the opcode definitions, using wide integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    longint sa, sb, ua, ub, p, r;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sh = int'(b[4:0]);
    p  = longint'(64'd1) << sh;
    case (op)
      4'd0: r = ua + ub;
      4'd1: r = ua - ub;
      4'd2: r = longint'({32'h0, a & b});
      4'd3: r = longint'({32'h0, a | b});
      4'd4: r = longint'({32'h0, a ^ b});
      4'd5: r = ua * p;
      4'd6: r = (sa < 0) ? (sa - (p - 1)) / p : sa / p;
      4'd7: r = ua / p;
      4'd8: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd9: r = (ua < ub) ? 64'd1 : 64'd0;
      default: r = 64'd0;
    endcase
    return r[31:0];
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  // random-phase model state
  logic        m_valid, m_id, m_err, m_last;
  logic [31:0] m_data;
  logic        p_valid[2];
  logic [31:0] p_a[2], p_b[2];
  logic [3:0]  p_op[2];

  initial begin
    vecs[0]  = '{1'b0, 32'd5,          32'd7,          ALU_ADD,  32'd12,         1'b0};
    vecs[1]  = '{1'b1, 32'd3,          32'd5,          ALU_SUB,  32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{1'b0, 32'd1234,       32'd5,          4'hC,     32'h0,          1'b1};
    vecs[3]  = '{1'b1, 32'd1,          32'h21,         ALU_SLL,  32'd2,          1'b0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          ALU_SLT,  32'd1,          1'b0};
    vecs[5]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,          ALU_SLTU, 32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  ALU_AND,  32'hF000_F000,  1'b0};
    vecs[7]  = '{1'b1, 32'hF0F0_F0F0,  32'h0F0F_0000,  ALU_OR,   32'hFFFF_F0F0,  1'b0};
    vecs[8]  = '{1'b0, 32'hAAAA_5555,  32'hFFFF_0000,  ALU_XOR,  32'h5555_5555,  1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0000,  32'h24,         ALU_SRA,  32'hF800_0000,  1'b0};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'd4,          ALU_SRL,  32'h0800_0000,  1'b0};
    vecs[11] = '{1'b1, 32'd77,         32'd3,          4'hF,     32'h0,          1'b1};
    vecs[12] = '{1'b0, 32'd1,          32'hFFFF_FFFF,  ALU_SLT,  32'd0,          1'b0};
    vecs[13] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          ALU_ADD,  32'd0,          1'b0};

    idle();
    do_reset();

    // Directed table: each op issued alone with the consumer always ready
    foreach (vecs[i]) begin
      @(negedge clk);
      idle();
      put(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      chk1($sformatf("vec%0d_ready0", i), bus_if.req0_ready, !vecs[i].id);
      chk1($sformatf("vec%0d_ready1", i), bus_if.req1_ready, vecs[i].id);
      @(negedge clk);
      idle();
      #1;
      chk1($sformatf("vec%0d_rsp_valid", i), bus_if.rsp_valid, 1'b1);
      chk($sformatf("vec%0d_rsp_data", i), bus_if.rsp_data, vecs[i].exp_data);
      chk1($sformatf("vec%0d_rsp_id", i), bus_if.rsp_id, vecs[i].id);
      chk1($sformatf("vec%0d_rsp_err", i), bus_if.rsp_err, vecs[i].exp_err);
    end

    // Contention: both valid for four cycles, grants alternate starting at 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      put(1'b0, 32'h10, 32'h1, ALU_ADD);
      put(1'b1, 32'h20, 32'h2, ALU_ADD);
      #1;
      chk1($sformatf("rr%0d_ready0", k), bus_if.req0_ready, (k % 2) == 0);
      chk1($sformatf("rr%0d_ready1", k), bus_if.req1_ready, (k % 2) == 1);
      if (k > 0) begin
        chk1($sformatf("rr%0d_rsp_id", k), bus_if.rsp_id, ((k - 1) % 2) == 1);
        chk($sformatf("rr%0d_rsp_data", k), bus_if.rsp_data, ((k - 1) % 2) == 1 ? 32'h22 : 32'h11);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk1("rr_last_rsp_id", bus_if.rsp_id, 1'b1);
    chk("rr_last_rsp_data", bus_if.rsp_data, 32'h22);

    // Backpressure: buffer full, consumer stalls three cycles, then takes it
    do_reset();
    @(negedge clk);
    idle();
    put(1'b1, 32'd3, 32'd5, ALU_SUB);
    #1;
    chk1("bp_fill_ready1", bus_if.req1_ready, 1'b1);
    @(negedge clk);
    idle();
    bus_if.rsp_ready = 1'b0;
    put(1'b0, 32'd7, 32'd8, ALU_ADD);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1($sformatf("bp%0d_ready0", k), bus_if.req0_ready, 1'b0);
      chk1($sformatf("bp%0d_rsp_valid", k), bus_if.rsp_valid, 1'b1);
      chk($sformatf("bp%0d_rsp_data", k), bus_if.rsp_data, 32'hFFFF_FFFE);
      @(negedge clk);
    end
    bus_if.rsp_ready = 1'b1;
    #1;
    chk1("bp_release_ready0", bus_if.req0_ready, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("bp_new_rsp_data", bus_if.rsp_data, 32'd15);
    chk1("bp_new_rsp_id", bus_if.rsp_id, 1'b0);

    // Reset mid-stall: the buffered result vanishes and priority restarts
    @(negedge clk);
    idle();
    put(1'b0, 32'd9, 32'd1, ALU_ADD);
    @(negedge clk);
    idle();
    bus_if.rsp_ready = 1'b0;
    #1;
    chk1("rs_full_valid", bus_if.rsp_valid, 1'b1);
    chk("rs_full_data", bus_if.rsp_data, 32'd10);
    @(negedge clk);
    rst = 1'b1;
    put(1'b0, 32'd1, 32'd1, ALU_ADD);
    #1;
    chk1("rs_ready0_in_reset", bus_if.req0_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus_if.rsp_ready = 1'b0;
    #1;
    chk1("rs_valid_after_reset", bus_if.rsp_valid, 1'b0);
    chk("rs_data_after_reset", bus_if.rsp_data, 32'h0);
    @(negedge clk);
    idle();
    put(1'b0, 32'd2, 32'd2, ALU_ADD);
    put(1'b1, 32'd3, 32'd3, ALU_ADD);
    #1;
    chk1("rs_prio_ready0", bus_if.req0_ready, 1'b1);
    chk1("rs_prio_ready1", bus_if.req1_ready, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk1("rs_prio_rsp_id", bus_if.rsp_id, 1'b0);
    chk("rs_prio_rsp_data", bus_if.rsp_data, 32'd4);

    // Random traffic against the model
    do_reset();
    m_valid = 1'b0; m_data = 32'h0; m_id = 1'b0; m_err = 1'b0; m_last = 1'b1;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic can, gv, g, pref;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!p_valid[r] && ($urandom_range(0, 1) == 1)) begin
          p_valid[r] = 1'b1;
          p_a[r]  = $urandom;
          p_b[r]  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
          p_op[r] = 4'($urandom_range(0, 15));
        end
      end
      bus_if.req0_valid = p_valid[0]; bus_if.req0_a = p_a[0]; bus_if.req0_b = p_b[0]; bus_if.req0_op = p_op[0];
      bus_if.req1_valid = p_valid[1]; bus_if.req1_a = p_a[1]; bus_if.req1_b = p_b[1]; bus_if.req1_op = p_op[1];
      bus_if.rsp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      chk1("rnd_rsp_valid", bus_if.rsp_valid, m_valid);
      if (m_valid) begin
        chk("rnd_rsp_data", bus_if.rsp_data, m_data);
        chk1("rnd_rsp_id", bus_if.rsp_id, m_id);
        chk1("rnd_rsp_err", bus_if.rsp_err, m_err);
      end
      can  = !m_valid || bus_if.rsp_ready;
      pref = !m_last;
      gv   = can && (p_valid[0] || p_valid[1]);
      g    = p_valid[pref] ? pref : !pref;
      chk1("rnd_ready0", bus_if.req0_ready, gv && (g == 1'b0));
      chk1("rnd_ready1", bus_if.req1_ready, gv && (g == 1'b1));
      if (gv) begin
        m_valid = 1'b1;
        m_data  = ref_alu(p_a[g], p_b[g], p_op[g]);
        m_id    = g;
        m_err   = (p_op[g] > 4'd9);
        m_last  = g;
        p_valid[g] = 1'b0;
      end else if (bus_if.rsp_ready) begin
        m_valid = 1'b0;
      end
    end

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_arbiter.md
# exu_arbiter

Two-requester arbiter and sequencer for the shared `exu` ALU datapath. It accepts operation requests from two clients, such as the integer issue stage and the address/CSR helper. A round-robin policy picks one request per cycle, drives it through a single `exu` instance and registers the result into a one-entry response buffer with valid/ready handshake. It sits between the issue logic and the ALU so that one ALU serves both clients without structural-hazard logic in either.

## Interface
- `RESET_PRIO`, default 0: requester that wins the first contended grant after reset (0 or 1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_a`, `req0_b`  in  32  requester 0 operands.
- `req0_op`  in  4  requester 0 ALU opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: as requester 0, for requester 1.
- `rsp_valid`  out  1  response buffer holds a result.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_id`  out  1  index of the requester that issued the buffered operation.
- `rsp_data`  out  32  ALU result.
- `rsp_err`  out  1  buffered operation had an illegal opcode.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 SRL.
  - 8 SLT (signed), 9 SLTU.
  - 10–15 are illegal: result is 0 and `rsp_err` = 1.
- Shift operand rule: for opcodes 5–7 the arbiter drives `exu` port_b = {27'b0, b[4:0]}. For every other opcode, b is passed unmodified.
- Capacity: `can_accept` = !rsp_valid | rsp_ready (buffer empty, or being drained this cycle).
- Arbitration (combinational):
  - Only one requester valid: that requester is granted if `can_accept`.
  - Both valid: the requester not equal to `last_grant` is granted.
  - `reqN_ready` = grant to N. At most one ready is high per cycle.
  - Ready depends combinationally on `rsp_ready`.
- The granted operands and opcode are muxed into `exu`.
- On an accept edge:
  - rsp_data ← exu result.
  - rsp_id ← granted index.
  - rsp_err ← (op > 9).
  - rsp_valid ← 1.
  - last_grant ← granted index.
- On a drain edge with no accept: rsp_valid ← 0.
- On simultaneous drain and accept: the buffer is overwritten with the new result and rsp_valid stays 1.
- Requester rule: valid and payload must stay stable until ready. Dropping valid before ready is legal; the request is simply not taken.
- Consumer rule: while rsp_valid=1 and rsp_ready=0, the outputs rsp_data, rsp_id and rsp_err are held constant.
- Two-state control is implicit in `rsp_valid`:
  - EMPTY goes to FULL on accept.
  - FULL goes to FULL on accept-while-drain or on stall.
  - FULL goes to EMPTY on drain without accept.

## Timing
- Latency: request accepted at edge N, response visible from N (rsp_valid high in cycle N+1).
- Throughput: one operation per cycle while rsp_ready is held high. With both requesters busy they alternate 0,1,0,1…
- Reset values:
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0.
  - last_grant = !RESET_PRIO.
  - req0_ready and req1_ready are 0 during the reset cycle.
- Reset mid-operation: the buffered result is discarded, with no response delivered. Round-robin pointer returns to its reset value. Any request presented during reset is not accepted.
- Starvation bound: a continuously valid requester is granted within 2 accept opportunities.

## Structure
- Shared package `exu_pkg`:
  - Opcode constants ALU_ADD=4'h0 … ALU_SLTU=4'h9.
  - ALU_OP_MAX=4'h9.
  - Width constant XLEN=32.
- One sub-module: the existing `exu`, instantiated once, unmodified. Arbitration and buffer logic live in `exu_arbiter` itself.

## Test plan
- Single add: req0 ADD a=5, b=7, rsp_ready=1 → req0_ready=1 in the same cycle. Next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_err=0.
- Contention/fairness: both requesters valid for 4 cycles after reset with RESET_PRIO=0, rsp_ready=1 → grant order 0,1,0,1. rsp_id follows one cycle later.
- Backpressure: fill the buffer (req1 SUB 3−5 → 0xFFFF_FFFE), then hold rsp_ready=0 for 3 cycles with req0 valid → req0_ready=0 throughout and rsp_data stable. Raising rsp_ready accepts req0 in that same cycle.
- Illegal op and shift masking:
  - req0 op=4'hC → rsp_data=0, rsp_err=1.
  - req1 SLL a=1, b=0x21 → rsp_data=2.
- Signed/unsigned compare: SLT a=0xFFFF_FFFF, b=1 → 1. SLTU with the same operands → 0.
- Reset mid-stall: buffer full and rsp_ready=0, assert rst for one cycle → rsp_valid=0 next cycle and the old result is never delivered. The first contended grant afterwards goes to RESET_PRIO.
